// File: rtl/fir_sample_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_sample_sequencer: runs an HLS FIR core once per sample and serves     |
// | its coefficient reads; results carry measured start-to-done latency.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module fir_sample_sequencer #(
  parameter int DATA_W  = 32,
  parameter int NTAPS   = 11,
  parameter int ADDR_W  = 4,
  parameter int LAT_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [LAT_W-1:0]  m_latency,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_ready,
  input  logic              err_clr,
  output logic              timeout_err,
  output logic              busy,
  output logic              core_start,
  output logic              core_rst,
  input  logic              core_done,
  output logic [DATA_W-1:0] core_x,
  input  logic [DATA_W-1:0] core_return,
  input  logic [ADDR_W-1:0] core_c_addr,
  input  logic              core_c_ce,
  output logic [DATA_W-1:0] core_c_q
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  localparam logic [LAT_W-1:0]  C_TIMEOUT = LAT_W'(TIMEOUT);
  localparam logic [LAT_W-1:0]  C_CNT_MAX = '1;
  localparam logic [ADDR_W:0]   C_NTAPS   = (ADDR_W+1)'(NTAPS);

  state_t            r_state;
  state_t            w_next;
  logic              r_alive;
  logic              r_abort_2nd;
  logic [LAT_W-1:0]  r_cnt;
  logic [LAT_W-1:0]  w_cnt_inc;
  logic [DATA_W-1:0] r_bank [NTAPS];
  logic              w_idle;
  logic              w_accept;
  logic              w_timeout;
  logic              w_finish;
  logic              w_abort;

  // r_alive keeps the block (and the core) held for one cycle after reset release
  assign w_idle     = (r_state == S_IDLE) && r_alive;
  assign s_ready    = w_idle && !cfg_we;
  assign cfg_ready  = w_idle && cfg_we;
  assign w_accept   = s_valid && s_ready;
  assign w_cnt_inc  = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout  = (w_cnt_inc >= C_TIMEOUT);
  assign w_finish   = (r_state == S_WAIT) && core_done;
  assign w_abort    = (r_state == S_WAIT) && !core_done && w_timeout;

  assign m_valid    = (r_state == S_OUT);
  assign busy       = (r_state != S_IDLE);
  assign core_start = (r_state == S_START);
  assign core_rst   = !r_alive || (r_state == S_ABORT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (core_done)      w_next = S_OUT;
        else if (w_timeout) w_next = S_ABORT;
      end
      S_OUT:   if (m_ready) w_next = S_IDLE;
      S_ABORT: if (r_abort_2nd) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state     <= S_IDLE;
      r_alive     <= 1'b0;
      r_abort_2nd <= 1'b0;
      r_cnt       <= '0;
      m_data      <= '0;
      m_latency   <= '0;
      timeout_err <= 1'b0;
      core_x      <= '0;
      core_c_q    <= '0;
    end else begin
      r_state     <= w_next;
      r_alive     <= 1'b1;
      r_abort_2nd <= (r_state == S_ABORT) && !r_abort_2nd;
      if (r_state == S_START)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= w_cnt_inc;
      if (w_accept) core_x <= s_data;
      if (w_finish) begin
        m_data    <= core_return;
        m_latency <= w_cnt_inc;
      end
      if (w_abort)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
      if (core_c_ce)
        core_c_q <= ({1'b0, core_c_addr} < C_NTAPS) ? r_bank[core_c_addr] : '0;
    end
  end

  // Out-of-range write addresses match no tap and are silently dropped
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NTAPS; i++) r_bank[i] <= '0;
    end else begin
      for (int i = 0; i < NTAPS; i++)
        if (cfg_ready && (cfg_addr == ADDR_W'(i))) r_bank[i] <= cfg_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_sequencer.sv
`default_nettype none
// Bench for fir_sample_sequencer: behavioural FIR core plus reference model
// and scoreboard of expected results/latencies.
module tb_fir_sample_sequencer;
  localparam int DATA_W = 32, NTAPS = 11, ADDR_W = 4, LAT_W = 16, TIMEOUT = 1023;
  localparam int BOUND = 2000;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  logic s_valid, s_ready, m_valid, m_ready;
  logic [DATA_W-1:0] s_data, m_data;
  logic [LAT_W-1:0]  m_latency;
  logic cfg_we, cfg_ready, err_clr, timeout_err, busy, core_start, core_rst, core_done;
  logic [ADDR_W-1:0] cfg_addr, core_c_addr;
  logic [DATA_W-1:0] cfg_data, core_x, core_return, core_c_q;
  logic core_c_ce;

  always #5 ap_clk = ~ap_clk;

  fir_sample_sequencer #(.DATA_W(DATA_W), .NTAPS(NTAPS), .ADDR_W(ADDR_W),
                         .LAT_W(LAT_W), .TIMEOUT(TIMEOUT)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_latency(m_latency),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .err_clr(err_clr), .timeout_err(timeout_err), .busy(busy),
    .core_start(core_start), .core_rst(core_rst), .core_done(core_done),
    .core_x(core_x), .core_return(core_return),
    .core_c_addr(core_c_addr), .core_c_ce(core_c_ce), .core_c_q(core_c_q)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LAT_W-1:0]  lat;
  } exp_t;
  exp_t sb[$];

  logic [DATA_W-1:0] ref_coef [NTAPS];
  logic [DATA_W-1:0] ref_hist [NTAPS];

  // core behaviour knobs (written by the stimulus process only)
  bit trig = 0, hang = 0, probe = 0;

  // ---------------- behavioural FIR core ----------------
  logic [DATA_W-1:0] hist [NTAPS];
  logic [DATA_W-1:0] acc, probe_or;
  bit aborted;

  initial begin
    core_done = 0; core_return = '0; core_c_addr = '0; core_c_ce = 0; probe_or = '0;
    for (int k = 0; k < NTAPS; k++) hist[k] = '0;
    forever begin
      @(negedge ap_clk);
      if (core_rst) begin
        for (int k = 0; k < NTAPS; k++) hist[k] = '0;
        core_c_ce = 0; core_done = 0;
      end else if (core_start) begin
        for (int k = NTAPS-1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = core_x;
        acc = '0; aborted = 0; probe_or = '0;
        for (int i = 0; i < NTAPS && !aborted; i++) begin
          core_c_addr = ADDR_W'(i); core_c_ce = 1;
          @(negedge ap_clk);
          if (core_rst) aborted = 1;
          acc = acc + core_c_q * hist[i];
          core_c_ce = 0;
          if (trig) repeat (2) begin
            @(negedge ap_clk);
            if (core_rst) aborted = 1;
          end
        end
        if (probe && !aborted) begin
          for (int a = NTAPS; a < (1 << ADDR_W); a++) begin
            core_c_addr = ADDR_W'(a); core_c_ce = 1;
            @(negedge ap_clk);
            probe_or = probe_or | core_c_q;
            core_c_ce = 0;
          end
        end
        if (hang && !aborted) begin
          while (!core_rst) @(negedge ap_clk);
          aborted = 1;
        end
        if (aborted) begin
          for (int k = 0; k < NTAPS; k++) hist[k] = '0;
        end else begin
          core_return = acc; core_done = 1;
          @(negedge ap_clk);
          core_done = 0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_step(input logic [DATA_W-1:0] x, output logic [DATA_W-1:0] y);
    for (int k = NTAPS-1; k > 0; k--) ref_hist[k] = ref_hist[k-1];
    ref_hist[0] = x;
    y = '0;
    for (int k = 0; k < NTAPS; k++) y = y + ref_coef[k] * ref_hist[k];
  endtask

  task automatic push_expected(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    exp_t e;
    ref_step(x, y);
    e.data = y;
    e.lat  = LAT_W'(NTAPS * (trig ? 3 : 1) + (probe ? ((1 << ADDR_W) - NTAPS) : 0));
    sb.push_back(e);
  endtask

  task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n = 0;
    cfg_we = 1; cfg_addr = a; cfg_data = d; #1;
    while (!cfg_ready && n < BOUND) begin @(negedge ap_clk); #1; n++; end
    check("cfg_write ready", cfg_ready, 1);
    @(negedge ap_clk);
    cfg_we = 0;
    if (int'(a) < NTAPS) ref_coef[a] = d;
  endtask

  task automatic send(input logic [DATA_W-1:0] x);
    int n = 0;
    s_valid = 1; s_data = x; #1;
    while (!s_ready && n < BOUND) begin @(negedge ap_clk); #1; n++; end
    check("send s_ready", s_ready, 1);
    push_expected(x);
    @(negedge ap_clk);
    s_valid = 0;
  endtask

  task automatic recv(input string tag, input int hold);
    int n = 0;
    bit bad = 0;
    logic [DATA_W-1:0] d;
    logic [LAT_W-1:0]  l;
    exp_t e;
    #1;
    while (!m_valid && n < BOUND) begin @(negedge ap_clk); #1; n++; end
    check({tag, " m_valid"}, m_valid, 1);
    d = m_data; l = m_latency;
    repeat (hold) begin
      @(negedge ap_clk); #1;
      if (m_valid !== 1'b1 || m_data !== d || m_latency !== l || s_ready !== 1'b0) bad = 1;
    end
    if (hold > 0) check({tag, " held stable"}, bad, 0);
    m_ready = 1; #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, " m_data"}, m_data, e.data);
      check({tag, " m_latency"}, m_latency, e.lat);
    end
    @(negedge ap_clk);
    m_ready = 0; #1;
    check({tag, " m_valid drop"}, m_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    bit bad;
    for (int k = 0; k < NTAPS; k++) begin ref_coef[k] = '0; ref_hist[k] = '0; end
    ap_rst_n = 0; s_valid = 1; s_data = 32'hABCD; m_ready = 0;
    cfg_we = 1; cfg_addr = '0; cfg_data = 32'h55; err_clr = 0;
    repeat (3) @(negedge ap_clk);
    #1;
    check("rst ctrl {m_valid,busy,start,err,cfg_ready,s_ready,core_rst}",
          {m_valid, busy, core_start, timeout_err, cfg_ready, s_ready, core_rst}, 7'b0000001);
    check("rst m_data", m_data, 0);
    check("rst m_latency", m_latency, 0);
    check("rst core_x/core_c_q", {core_x, core_c_q}, 0);
    s_valid = 0; cfg_we = 0;
    @(negedge ap_clk);
    ap_rst_n = 1; #1;
    check("release {s_ready,core_rst}", {s_ready, core_rst}, 2'b01);
    @(negedge ap_clk); #1;
    check("alive {s_ready,core_rst}", {s_ready, core_rst}, 2'b10);

    // impulse response through coefficients 1..11
    for (int i = 0; i < NTAPS; i++) cfg_write(ADDR_W'(i), DATA_W'(i + 1));
    send(32'd1); #1;
    check("start pulse", core_start, 1);
    check("core_x latched", core_x, 1);
    recv("impulse0", 0);
    for (int i = 1; i < NTAPS; i++) begin
      send(32'd0);
      recv("impulse", 0);
    end
    check("core_c_q holds", core_c_q, ref_coef[NTAPS-1]);

    // output backpressure
    send(32'd3);
    recv("backpressure", 5);

    // config wins over a same-cycle sample
    cfg_we = 1; cfg_addr = 4'd0; cfg_data = 32'd100; s_valid = 1; s_data = 32'd2; #1;
    check("arb {cfg_ready,s_ready}", {cfg_ready, s_ready}, 2'b10);
    ref_coef[0] = 32'd100;
    @(negedge ap_clk);
    cfg_we = 0; #1;
    check("arb sample next", s_ready, 1);
    push_expected(32'd2);
    @(negedge ap_clk);
    s_valid = 0;
    recv("arb", 0);

    // config held off while busy
    send(32'd4);
    cfg_we = 1; cfg_addr = 4'd1; cfg_data = 32'd200; #1;
    n = 0; bad = 0;
    while (!m_valid && n < BOUND) begin
      if (cfg_ready) bad = 1;
      @(negedge ap_clk); #1; n++;
    end
    check("cfg blocked when busy", bad, 0);
    recv("cfg_busy", 0);
    check("cfg taken in idle", cfg_ready, 1);
    @(negedge ap_clk);
    cfg_we = 0;
    ref_coef[1] = 32'd200;

    // out-of-range write and read
    cfg_write(4'd12, 32'hDEAD);
    probe = 1;
    send(32'd6);
    recv("probe", 0);
    check("oob read zero", probe_or, 0);
    probe = 0;

    // latency with and without core trigger
    send(32'd7);
    recv("lat_trig0", 0);
    trig = 1;
    send(32'd7);
    recv("lat_trig1", 0);
    trig = 0;

    // watchdog
    hang = 1;
    s_valid = 1; s_data = 32'h77; #1;
    n = 0;
    while (!s_ready && n < BOUND) begin @(negedge ap_clk); #1; n++; end
    @(negedge ap_clk);
    s_valid = 0; #1;
    n = 0; bad = 0;
    while (!core_rst && n < 1100) begin
      @(negedge ap_clk); #1; n++;
      if (m_valid) bad = 1;
    end
    check("watchdog cycles", n, TIMEOUT + 1);
    check("abort {err,busy}", {timeout_err, busy}, 2'b11);
    @(negedge ap_clk); #1;
    check("abort core_rst 2nd", core_rst, 1);
    @(negedge ap_clk); #1;
    check("after abort {core_rst,busy,err}", {core_rst, busy, timeout_err}, 3'b001);
    check("abort no m_valid", bad | m_valid, 0);
    hang = 0;
    for (int k = 0; k < NTAPS; k++) ref_hist[k] = '0;
    err_clr = 1;
    @(negedge ap_clk);
    err_clr = 0; #1;
    check("err_clr", timeout_err, 0);

    // reset in the middle of a run
    send(32'd5);
    repeat (4) @(negedge ap_clk);
    #1;
    check("mid-wait busy", busy, 1);
    ap_rst_n = 0; #1;
    check("mid rst {busy,m_valid,core_rst,s_ready}", {busy, m_valid, core_rst, s_ready}, 4'b0010);
    sb.delete();
    for (int k = 0; k < NTAPS; k++) begin ref_coef[k] = '0; ref_hist[k] = '0; end
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1; #1;
    check("mid release {s_ready,core_rst}", {s_ready, core_rst}, 2'b01);
    @(negedge ap_clk); #1;
    check("mid alive {s_ready,core_rst}", {s_ready, core_rst}, 2'b10);
    send(32'd9);
    recv("post_reset", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
